// File: rtl/netlist_pkg.sv
// Shared types and sizing for the net degree collector.
// Optional driver checking is controlled by the NET_DRV_CHECK_EN macro.
package netlist_pkg;

    localparam int NUM_NETS = 11;
    localparam int NET_W    = $clog2(NUM_NETS);
    localparam int CNT_W    = 4;
    localparam int DRV_W    = 2;

    typedef logic [NET_W-1:0] net_id_t;
    typedef logic [CNT_W-1:0] pin_cnt_t;
    typedef logic [DRV_W-1:0] drv_cnt_t;

    localparam pin_cnt_t CNT_MAX  = {CNT_W{1'b1}};
    localparam drv_cnt_t DRV_MAX  = {DRV_W{1'b1}};
    localparam net_id_t  NET_LAST = net_id_t'(NUM_NETS - 1);

    typedef enum logic [1:0] {
        ACCUM,
        SCAN,
        DONE
    } coll_state_e;

    function automatic logic net_in_range(input net_id_t n);
        return n <= NET_LAST;
    endfunction

endpackage

// File: rtl/net_count_table.sv
// Per-net saturating pin counters (and driver counters when NET_DRV_CHECK_EN
// is defined) with one increment port, one scan read port and a global clear.
module net_count_table
    import netlist_pkg::*;
(
    input  logic     clk,
    input  logic     clr,
    input  logic     inc_en,
    input  net_id_t  inc_net,
`ifdef NET_DRV_CHECK_EN
    input  logic     inc_drv,
`endif
    input  net_id_t  rd_net,
    output pin_cnt_t rd_cnt
`ifdef NET_DRV_CHECK_EN
    ,
    output drv_cnt_t rd_drv
`endif
);

    pin_cnt_t cnt_q [NUM_NETS];
`ifdef NET_DRV_CHECK_EN
    drv_cnt_t drv_q [NUM_NETS];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NETS; gi++) begin : g_entry
            logic     hit;
            pin_cnt_t cnt_reg;

            assign hit       = inc_en && (inc_net == net_id_t'(gi));
            assign cnt_q[gi] = cnt_reg;

            always_ff @(posedge clk) begin
                if (clr) begin
                    cnt_reg <= '0;
                end else if (hit && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

`ifdef NET_DRV_CHECK_EN
            drv_cnt_t drv_reg;

            assign drv_q[gi] = drv_reg;

            always_ff @(posedge clk) begin
                if (clr) begin
                    drv_reg <= '0;
                end else if (hit && inc_drv && (drv_reg != DRV_MAX)) begin
                    drv_reg <= drv_reg + 1'b1;
                end
            end
`endif
        end
    endgenerate

    // The scan pointer runs one past the last net; read zero there.
    always_comb begin
        rd_cnt = '0;
        if (net_in_range(rd_net)) begin
            rd_cnt = cnt_q[rd_net];
        end
    end

`ifdef NET_DRV_CHECK_EN
    always_comb begin
        rd_drv = '0;
        if (net_in_range(rd_net)) begin
            rd_drv = drv_q[rd_net];
        end
    end
`endif

endmodule

// File: rtl/net_degree_collector.sv
// Collects per-net pin/driver counts from a pin-connection stream, then scans
// and emits one summary per populated net. Driver check: NET_DRV_CHECK_EN.
module net_degree_collector
    import netlist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NET_W-1:0] in_net,
    input  logic             in_is_drv,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NET_W-1:0] out_net,
    output logic [CNT_W-1:0] out_pins,
    output logic             out_err,
    output logic             done,
    output logic             err_range
);

    localparam logic [NET_W:0] PTR_END = (NET_W+1)'(NUM_NETS);

    coll_state_e     state_reg, state_next;
    logic [NET_W:0]  ptr_reg, ptr_next;
    logic            in_ready_reg, in_ready_next;
    logic            out_valid_reg, out_valid_next;
    net_id_t         out_net_reg, out_net_next;
    pin_cnt_t        out_pins_reg, out_pins_next;
    logic            out_err_reg, out_err_next;
    logic            done_reg, done_next;
    logic            err_range_reg, err_range_next;

    logic            accept;
    logic            in_range;
    logic            inc_en;
    logic            tbl_clr;
    net_id_t         rd_net;
    pin_cnt_t        rd_cnt;
`ifdef NET_DRV_CHECK_EN
    drv_cnt_t        rd_drv;
`else
    logic            unused_in_is_drv;
    assign unused_in_is_drv = in_is_drv;
`endif

    // in_ready is only ever high while in ACCUM, so it alone qualifies accepts.
    assign accept   = in_valid && in_ready_reg;
    assign in_range = net_in_range(in_net);
    assign inc_en   = accept && in_range;
    assign tbl_clr  = rst || (state_reg == DONE);
    assign rd_net   = ptr_reg[NET_W-1:0];

    net_count_table u_table (
        .clk     (clk),
        .clr     (tbl_clr),
        .inc_en  (inc_en),
        .inc_net (in_net),
`ifdef NET_DRV_CHECK_EN
        .inc_drv (in_is_drv),
`endif
        .rd_net  (rd_net),
        .rd_cnt  (rd_cnt)
`ifdef NET_DRV_CHECK_EN
        ,
        .rd_drv  (rd_drv)
`endif
    );

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        out_valid_next = out_valid_reg;
        out_net_next   = out_net_reg;
        out_pins_next  = out_pins_reg;
        out_err_next   = out_err_reg;
        err_range_next = err_range_reg || (accept && !in_range);

        case (state_reg)
            ACCUM: begin
                ptr_next = '0;
                if (accept && in_last) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // Output slot is free or being consumed: load the next net.
                if (!out_valid_reg || out_ready) begin
                    if (ptr_reg == PTR_END) begin
                        out_valid_next = 1'b0;
                        state_next     = DONE;
                    end else begin
                        out_valid_next = (rd_cnt != '0);
                        out_net_next   = rd_net;
                        out_pins_next  = rd_cnt;
`ifdef NET_DRV_CHECK_EN
                        out_err_next   = (rd_drv != drv_cnt_t'(1));
`else
                        out_err_next   = 1'b0;
`endif
                        ptr_next       = ptr_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                ptr_next   = '0;
                state_next = ACCUM;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase

        in_ready_next = (state_next == ACCUM);
        done_next     = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            ptr_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_net_reg   <= '0;
            out_pins_reg  <= '0;
            out_err_reg   <= 1'b0;
            done_reg      <= 1'b0;
            err_range_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            out_net_reg   <= out_net_next;
            out_pins_reg  <= out_pins_next;
            out_err_reg   <= out_err_next;
            done_reg      <= done_next;
            err_range_reg <= err_range_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_net   = out_net_reg;
    assign out_pins  = out_pins_reg;
    assign out_err   = out_err_reg;
    assign done      = done_reg;
    assign err_range = err_range_reg;

endmodule

// File: tb/tb_net_degree_collector.sv
// Directed, table-driven bench for net_degree_collector.
module tb_net_degree_collector;
    import netlist_pkg::*;

`ifdef NET_DRV_CHECK_EN
    localparam int DRV_EN = 1;
`else
    localparam int DRV_EN = 0;
`endif

    logic     clk = 1'b0;
    logic     rst;
    logic     in_valid;
    logic     in_ready;
    net_id_t  in_net;
    logic     in_is_drv;
    logic     in_last;
    logic     out_valid;
    logic     out_ready;
    net_id_t  out_net;
    pin_cnt_t out_pins;
    logic     out_err;
    logic     done;
    logic     err_range;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        net_id_t net;
        logic    drv;
        logic    last;
    } rec_t;

    typedef struct {
        net_id_t  net;
        pin_cnt_t pins;
        logic     err;
    } sum_t;

    rec_t rec_q[$];
    sum_t exp_q[$];

    always #5 clk = ~clk;

    net_degree_collector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_net    (in_net),
        .in_is_drv (in_is_drv),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_net   (out_net),
        .out_pins  (out_pins),
        .out_err   (out_err),
        .done      (done),
        .err_range (err_range)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input net_id_t n, input logic d, input logic l);
        int k = 0;
        in_valid  = 1'b1;
        in_net    = n;
        in_is_drv = d;
        in_last   = l;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic feed();
        foreach (rec_q[i]) send(rec_q[i].net, rec_q[i].drv, rec_q[i].last);
    endtask

    // Compare the scan output against exp_q; stall net bp_net for 3 cycles.
    task automatic collect(input int bp_net, output int lat);
        int       idx     = 0;
        int       cyc     = 0;
        int       bp_left = 0;
        int       first   = -1;
        bit       seen_bp = 1'b0;
        bit       got_done = 1'b0;
        net_id_t  h_net   = '0;
        pin_cnt_t h_pins  = '0;
        out_ready = 1'b1;
        while (cyc < 300 && !got_done) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (out_valid && first < 0) first = cyc;
                if (bp_left > 0) begin
                    chk("bp_valid_held", int'(out_valid), 1);
                    chk("bp_net_held", int'(out_net), int'(h_net));
                    chk("bp_pins_held", int'(out_pins), int'(h_pins));
                end
                if (out_valid && int'(out_net) == bp_net && !seen_bp) begin
                    seen_bp = 1'b1;
                    bp_left = 3;
                    h_net   = out_net;
                    h_pins  = out_pins;
                end
                if (bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                end else begin
                    out_ready = 1'b1;
                    if (out_valid) begin
                        $display("summary net=%0d pins=%0d err=%0d", out_net, out_pins, out_err);
                        if (idx < exp_q.size()) begin
                            chk("sum_net", int'(out_net), int'(exp_q[idx].net));
                            chk("sum_pins", int'(out_pins), int'(exp_q[idx].pins));
                            chk("sum_err", int'(out_err), int'(exp_q[idx].err));
                        end else begin
                            chk("extra_summary", idx + 1, exp_q.size());
                        end
                        idx++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", int'(got_done), 1);
        chk("summary_count", idx, exp_q.size());
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("ready_after_done", int'(in_ready), 1);
        lat = first;
    endtask

    initial begin
        int  lat;
        bit  found;
        bit  bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_net    = '0;
        in_is_drv = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_net", int'(out_net), 0);
        chk("rst_out_pins", int'(out_pins), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err_range", int'(err_range), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready), 1);

        // Sample netlist: driver + sink on every net, with backpressure on net 2
        rec_q.delete();
        exp_q.delete();
        for (int n = 0; n < NUM_NETS; n++) begin
            rec_q.push_back('{net: net_id_t'(n), drv: 1'b1, last: 1'b0});
            rec_q.push_back('{net: net_id_t'(n), drv: 1'b0, last: (n == NUM_NETS - 1)});
            exp_q.push_back('{net: net_id_t'(n), pins: pin_cnt_t'(2), err: 1'b0});
        end
        feed();
        chk("scan_in_ready_low", int'(in_ready), 0);
        collect(2, lat);
        chk("first_out_latency", lat, 1);

        // Saturation on net 3
        rec_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++)
            rec_q.push_back('{net: net_id_t'(3), drv: (i == 0), last: (i == 19)});
        exp_q.push_back('{net: net_id_t'(3), pins: pin_cnt_t'(15), err: 1'b0});
        feed();
        collect(-1, lat);

        // Driver check
        rec_q.delete();
        exp_q.delete();
        rec_q.push_back('{net: net_id_t'(0), drv: 1'b1, last: 1'b0});
        rec_q.push_back('{net: net_id_t'(5), drv: 1'b1, last: 1'b0});
        rec_q.push_back('{net: net_id_t'(5), drv: 1'b1, last: 1'b0});
        rec_q.push_back('{net: net_id_t'(6), drv: 1'b0, last: 1'b1});
        exp_q.push_back('{net: net_id_t'(0), pins: pin_cnt_t'(1), err: 1'b0});
        exp_q.push_back('{net: net_id_t'(5), pins: pin_cnt_t'(2), err: DRV_EN[0]});
        exp_q.push_back('{net: net_id_t'(6), pins: pin_cnt_t'(1), err: DRV_EN[0]});
        feed();
        collect(-1, lat);

        // Range error
        chk("err_range_clear", int'(err_range), 0);
        send(net_id_t'(13), 1'b1, 1'b0);
        chk("err_range_set", int'(err_range), 1);
        rec_q.delete();
        exp_q.delete();
        rec_q.push_back('{net: net_id_t'(1), drv: 1'b1, last: 1'b1});
        exp_q.push_back('{net: net_id_t'(1), pins: pin_cnt_t'(1), err: 1'b0});
        feed();
        collect(-1, lat);
        chk("err_range_sticky", int'(err_range), 1);

        // Reset while net 4's summary is pending
        rec_q.delete();
        for (int n = 0; n < 7; n++)
            rec_q.push_back('{net: net_id_t'(n), drv: 1'b1, last: (n == 6)});
        feed();
        found = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            if (out_valid && out_net == net_id_t'(4)) begin
                found = 1'b1;
                out_ready = 1'b0;
            end else begin
                if (out_valid) chk("pre_rst_pins", int'(out_pins), 1);
                @(negedge clk);
            end
        end
        chk("rst_pending_found", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan_out_valid", int'(out_valid), 0);
        chk("midscan_in_ready", int'(in_ready), 0);
        chk("midscan_done", int'(done), 0);
        chk("midscan_err_range", int'(err_range), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || out_valid) bad = 1'b1;
        end
        chk("no_done_after_rst", int'(bad), 0);

        // Fresh stream after reset counts from zero
        rec_q.delete();
        exp_q.delete();
        rec_q.push_back('{net: net_id_t'(4), drv: 1'b1, last: 1'b1});
        exp_q.push_back('{net: net_id_t'(4), pins: pin_cnt_t'(1), err: 1'b0});
        feed();
        collect(-1, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
